alu_issue_unit: RTL and testbench

//  Initiator side of the ALU operand interface: owns the 32-entry integer register file and sequences one

---
 rtl/alu_issue_unit_if.sv | 52 +++++
 rtl/alu_issue_unit.sv | 135 +++++++++++++
 tb/tb_alu_issue_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_unit_if.sv
// Operand/handshake bundle between decode, the issue unit, the external ALU
// and the commit/trace consumer. The issue unit uses the slave view; the
// surrounding logic (decode, ALU, consumer) uses the master view.
interface alu_issue_unit_if #(
   parameter int XLEN = 32
);
   // request side (from decode)
   logic            req_valid;
   logic            req_ready;
   logic [3:0]      req_op;
   logic [4:0]      req_rs1;
   logic [4:0]      req_rs2;
   logic [XLEN-1:0] req_imm;
   logic            req_use_imm;
   logic [4:0]      req_rd;
   // ALU side
   logic [XLEN-1:0] alu_opdA;
   logic [XLEN-1:0] alu_opdB;
   logic [3:0]      alu_op_sel;
   logic [XLEN-1:0] alu_out;
   // response side (to commit/trace)
   logic            rsp_valid;
   logic            rsp_ready;
   logic [4:0]      rsp_rd;
   logic [XLEN-1:0] rsp_data;
   logic            rsp_err;
   // debug register read
   logic [4:0]      dbg_addr;
   logic [XLEN-1:0] dbg_data;

   modport master (
      output req_valid, req_op, req_rs1, req_rs2, req_imm, req_use_imm, req_rd,
      input  req_ready,
      input  alu_opdA, alu_opdB, alu_op_sel,
      output alu_out,
      input  rsp_valid, rsp_rd, rsp_data, rsp_err,
      output rsp_ready,
      output dbg_addr,
      input  dbg_data
   );

   modport slave (
      input  req_valid, req_op, req_rs1, req_rs2, req_imm, req_use_imm, req_rd,
      output req_ready,
      output alu_opdA, alu_opdB, alu_op_sel,
      input  alu_out,
      output rsp_valid, rsp_rd, rsp_data, rsp_err,
      input  rsp_ready,
      input  dbg_addr,
      output dbg_data
   );
endinterface

// File: rtl/alu_issue_unit.sv
// ALU issue unit: owns the 32-entry integer register file and runs one
// operation at a time through an external combinational ALU.
// Sequence: IDLE (accept, read operands) -> EXEC (ALU settles, write back)
// -> RESP (hold result until consumed) -> IDLE.
module alu_issue_unit #(
   parameter int XLEN       = 32,
   parameter bit CLEAR_REGS = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   alu_issue_unit_if.slave bus
);

   // ALU op codes
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_XOR  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_SRL  = 4'd5;
   localparam logic [3:0] OP_SRA  = 4'd6;
   localparam logic [3:0] OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;

   logic [XLEN-1:0] regs [0:31];
   logic [XLEN-1:0] opd_a;
   logic [XLEN-1:0] opd_b;
   logic [3:0]      op_sel;
   logic [4:0]      rd;
   logic            err;
   logic [XLEN-1:0] data;

   logic            accept;
   logic            illegal;
   logic            wr_en;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;

   // Codes above SLTU are the unlisted ones; they are executed as ADD and flagged.
   assign illegal  = (bus.req_op > OP_SLTU);
   assign accept   = (state == IDLE) && bus.req_valid;
   // No write-back for x0 or flagged ops. An async reset forces IDLE, so a
   // pending write-back is dropped in both register-file variants.
   assign wr_en    = (state == EXEC) && !err && (rd != 5'd0);

   // x0 reads as zero everywhere, so regs[0] is never consulted.
   assign rs1_data = (bus.req_rs1 == 5'd0)  ? '0 : regs[bus.req_rs1];
   assign rs2_data = (bus.req_rs2 == 5'd0)  ? '0 : regs[bus.req_rs2];

   assign bus.dbg_data   = (bus.dbg_addr == 5'd0) ? '0 : regs[bus.dbg_addr];
   assign bus.req_ready  = (state == IDLE);
   assign bus.rsp_valid  = (state == RESP);
   assign bus.rsp_rd     = rd;
   assign bus.rsp_data   = data;
   assign bus.rsp_err    = err;
   assign bus.alu_opdA   = opd_a;
   assign bus.alu_opdB   = opd_b;
   assign bus.alu_op_sel = op_sel;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: EXEC always lasts one cycle, RESP waits for the consumer.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.req_valid) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (bus.rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand/op registers load only on accept; result captured at the end of EXEC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opd_a  <= '0;
         opd_b  <= '0;
         op_sel <= OP_ADD;
         rd     <= 5'd0;
         err    <= 1'b0;
         data   <= '0;
      end else begin
         if (accept) begin
            opd_a  <= rs1_data;
            opd_b  <= bus.req_use_imm ? bus.req_imm : rs2_data;
            op_sel <= illegal ? OP_ADD : bus.req_op;
            rd     <= bus.req_rd;
            err    <= illegal;
         end
         if (state == EXEC) begin
            data <= bus.alu_out;
         end
      end
   end

   generate
      if (CLEAR_REGS) begin : g_clear_regs
         // Register file, cleared on reset.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < 32; i++) begin
                  regs[i] <= '0;
               end
            end else if (wr_en) begin
               regs[rd] <= bus.alu_out;
            end
         end
      end else begin : g_keep_regs
         // Register file, contents survive reset.
         always_ff @(posedge clk) begin
            if (wr_en) begin
               regs[rd] <= bus.alu_out;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: models the external ALU, runs a table of
// operations through the full handshake, then hand-written sequences for
// response back-pressure and reset during EXEC.
module tb_alu_issue_unit;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_XOR  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_SRL  = 4'd5;
   localparam logic [3:0] OP_SRA  = 4'd6;
   localparam logic [3:0] OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   alu_issue_unit_if #(.XLEN(32)) bus ();

   alu_issue_unit #(.XLEN(32), .CLEAR_REGS(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model of the external combinational ALU.
   always_comb begin
      case (bus.alu_op_sel)
         OP_ADD:  bus.alu_out = bus.alu_opdA + bus.alu_opdB;
         OP_SUB:  bus.alu_out = bus.alu_opdA - bus.alu_opdB;
         OP_XOR:  bus.alu_out = bus.alu_opdA ^ bus.alu_opdB;
         OP_OR:   bus.alu_out = bus.alu_opdA | bus.alu_opdB;
         OP_AND:  bus.alu_out = bus.alu_opdA & bus.alu_opdB;
         OP_SRL:  bus.alu_out = bus.alu_opdA >> bus.alu_opdB[4:0];
         OP_SRA:  bus.alu_out = $unsigned($signed(bus.alu_opdA) >>> bus.alu_opdB[4:0]);
         OP_SLL:  bus.alu_out = bus.alu_opdA << bus.alu_opdB[4:0];
         OP_SLT:  bus.alu_out = {31'd0, $signed(bus.alu_opdA) < $signed(bus.alu_opdB)};
         OP_SLTU: bus.alu_out = {31'd0, bus.alu_opdA < bus.alu_opdB};
         default: bus.alu_out = 32'hDEAD_BEEF;
      endcase
   end

   typedef struct {
      logic [3:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        use_imm;
      logic [4:0]  rd;
      logic [31:0] exp_data;
      logic        exp_err;
      logic [3:0]  exp_sel;
      logic [31:0] exp_dbg;
   } vec_t;

   localparam int NVEC = 14;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One full transaction: accept, EXEC, RESP, consume, then debug-read rd.
   task automatic do_op(input vec_t v);
      chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
      bus.req_op      = v.op;
      bus.req_rs1     = v.rs1;
      bus.req_rs2     = v.rs2;
      bus.req_imm     = v.imm;
      bus.req_use_imm = v.use_imm;
      bus.req_rd      = v.rd;
      bus.req_valid   = 1'b1;
      @(posedge clk); #1;
      bus.req_valid   = 1'b0;
      chk("exec_op_sel",    {28'd0, bus.alu_op_sel}, {28'd0, v.exp_sel});
      chk("exec_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("exec_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      @(posedge clk); #1;
      chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("rsp_rd",    {27'd0, bus.rsp_rd}, {27'd0, v.rd});
      chk("rsp_data",  bus.rsp_data, v.exp_data);
      chk("rsp_err",   {31'd0, bus.rsp_err}, {31'd0, v.exp_err});
      $display("txn op=%h rs1=%0d rs2=%0d imm=%h use_imm=%b rd=%0d -> data=%h err=%b",
               v.op, v.rs1, v.rs2, v.imm, v.use_imm, v.rd, bus.rsp_data, bus.rsp_err);
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      chk("post_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("post_req_ready", {31'd0, bus.req_ready}, 32'd1);
      bus.dbg_addr = v.rd;
      #1;
      chk("dbg_rd", bus.dbg_data, v.exp_dbg);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
      chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
      chk({tag, "_rsp_err"},   {31'd0, bus.rsp_err}, 32'd0);
      chk({tag, "_rsp_rd"},    {27'd0, bus.rsp_rd}, 32'd0);
      chk({tag, "_rsp_data"},  bus.rsp_data, 32'd0);
      chk({tag, "_opdA"},      bus.alu_opdA, 32'd0);
      chk({tag, "_opdB"},      bus.alu_opdB, 32'd0);
      chk({tag, "_op_sel"},    {28'd0, bus.alu_op_sel}, {28'd0, OP_ADD});
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;

      //        op       rs1 rs2 imm           ui  rd  data          err  sel      dbg
      vecs[0]  = '{OP_ADD,  5'd0, 5'd0, 32'd5,   1'b1, 5'd1,  32'd5,        1'b0, OP_ADD,  32'd5};
      vecs[1]  = '{OP_SUB,  5'd0, 5'd1, 32'd0,   1'b0, 5'd2,  32'hFFFFFFFB, 1'b0, OP_SUB,  32'hFFFFFFFB};
      vecs[2]  = '{OP_SRA,  5'd2, 5'd0, 32'd4,   1'b1, 5'd3,  32'hFFFFFFFF, 1'b0, OP_SRA,  32'hFFFFFFFF};
      vecs[3]  = '{OP_SLTU, 5'd2, 5'd0, 32'd1,   1'b1, 5'd6,  32'd0,        1'b0, OP_SLTU, 32'd0};
      vecs[4]  = '{OP_ADD,  5'd0, 5'd0, 32'd7,   1'b1, 5'd0,  32'd7,        1'b0, OP_ADD,  32'd0};
      vecs[5]  = '{4'hF,    5'd1, 5'd0, 32'd3,   1'b1, 5'd4,  32'd8,        1'b1, OP_ADD,  32'd0};
      vecs[6]  = '{OP_XOR,  5'd1, 5'd2, 32'd0,   1'b0, 5'd7,  32'hFFFFFFFE, 1'b0, OP_XOR,  32'hFFFFFFFE};
      vecs[7]  = '{OP_OR,   5'd1, 5'd0, 32'h10,  1'b1, 5'd8,  32'h15,       1'b0, OP_OR,   32'h15};
      vecs[8]  = '{OP_AND,  5'd2, 5'd0, 32'hF0,  1'b1, 5'd9,  32'hF0,       1'b0, OP_AND,  32'hF0};
      vecs[9]  = '{OP_SRL,  5'd2, 5'd0, 32'd28,  1'b1, 5'd10, 32'hF,        1'b0, OP_SRL,  32'hF};
      vecs[10] = '{OP_SLL,  5'd1, 5'd0, 32'h23,  1'b1, 5'd11, 32'h28,       1'b0, OP_SLL,  32'h28};
      vecs[11] = '{OP_SLT,  5'd2, 5'd1, 32'd0,   1'b0, 5'd12, 32'd1,        1'b0, OP_SLT,  32'd1};
      vecs[12] = '{OP_SLTU, 5'd2, 5'd1, 32'd0,   1'b0, 5'd13, 32'd0,        1'b0, OP_SLTU, 32'd0};
      vecs[13] = '{OP_SLT,  5'd1, 5'd2, 32'd0,   1'b0, 5'd14, 32'd0,        1'b0, OP_SLT,  32'd0};

      rst             = 1'b1;
      bus.req_valid   = 1'b0;
      bus.req_op      = 4'd0;
      bus.req_rs1     = 5'd0;
      bus.req_rs2     = 5'd0;
      bus.req_imm     = 32'd0;
      bus.req_use_imm = 1'b0;
      bus.req_rd      = 5'd0;
      bus.rsp_ready   = 1'b0;
      bus.dbg_addr    = 5'd0;

      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < NVEC; i++) begin
         do_op(vecs[i]);
      end

      // Back-pressure: response held, a second request must not be taken.
      bus.req_op      = OP_ADD;
      bus.req_rs1     = 5'd1;
      bus.req_imm     = 32'd1;
      bus.req_use_imm = 1'b1;
      bus.req_rd      = 5'd15;
      bus.req_valid   = 1'b1;
      @(posedge clk); #1;
      bus.req_imm     = 32'd100;
      bus.req_rd      = 5'd16;
      @(posedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         chk("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
         chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
         chk("hold_rsp_rd",    {27'd0, bus.rsp_rd}, 32'd15);
         chk("hold_rsp_data",  bus.rsp_data, 32'd6);
         chk("hold_opdB",      bus.alu_opdB, 32'd1);
         @(posedge clk); #1;
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      $display("txn hold rd=%0d data=%h released", bus.rsp_rd, bus.rsp_data);
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      chk("release_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("release_req_ready", {31'd0, bus.req_ready}, 32'd1);
      bus.dbg_addr = 5'd15;
      #1;
      chk("hold_x15", bus.dbg_data, 32'd6);
      bus.dbg_addr = 5'd16;
      #1;
      chk("hold_x16_untouched", bus.dbg_data, 32'd0);

      // Reset during EXEC: no response, no write-back, reset outputs.
      bus.req_op      = OP_ADD;
      bus.req_rs1     = 5'd0;
      bus.req_imm     = 32'd9;
      bus.req_use_imm = 1'b1;
      bus.req_rd      = 5'd5;
      bus.req_valid   = 1'b1;
      @(posedge clk); #1;
      bus.req_valid   = 1'b0;
      chk("pre_rst_in_exec", {31'd0, bus.req_ready}, 32'd0);
      rst = 1'b1;
      #1;
      chk_reset_outputs("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("after_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("after_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      bus.dbg_addr = 5'd5;
      #1;
      chk("after_rst_x5", bus.dbg_data, 32'd0);
      bus.dbg_addr = 5'd1;
      #1;
      chk("after_rst_x1_cleared", bus.dbg_data, 32'd0);
      $display("txn reset-in-exec rd=5 dropped");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
